// File: rtl/logic_gate_scheduler.sv
// rtl/logic_gate_scheduler.sv - round-robin shared bit-serial logic gate unit with tagged response
module logic_gate_scheduler #(
    parameter  int N_REQ = 4,
    parameter  int W     = 8,
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [3*N_REQ-1:0] req_op,
    input  logic [W*N_REQ-1:0] req_a,
    input  logic [W*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]   req_ready,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [ID_W-1:0]    resp_id,
    output logic [W-1:0]       resp_data,
    output logic               resp_err,
    output logic               busy
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [2:0] OP_RSVD = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_q, rr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [2:0]        op_q, op_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      res_q, res_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              win_found;
    logic [ID_W-1:0]   win_id;
    logic [ID_W-1:0]   scan_idx;
    int                scan_pos;
    logic [2:0]        sel_op;
    logic [W-1:0]      sel_a;
    logic [W-1:0]      sel_b;
    logic              accept;
    logic              last_bit;
    logic [ID_W-1:0]   id_next;

    logic              gate_a;
    logic              gate_b;
    logic              gate_y;
    logic [7:0]        op_dec;
    logic [7:0]        gate_terms;

    // Round-robin search starting at the pointer, wrapping at N_REQ.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_pos  = 0;
        scan_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_pos = int'(rr_q) + k;
            if (scan_pos >= N_REQ) begin
                scan_pos = scan_pos - N_REQ;
            end
            scan_idx = ID_W'(scan_pos);
            if (!win_found && req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_id    = scan_idx;
            end
        end
    end

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_id == ID_W'(i)) begin
                sel_op = req_op[3*i +: 3];
                sel_a  = req_a[W*i +: W];
                sel_b  = req_b[W*i +: W];
            end
        end
    end

    assign accept   = (state_q == S_IDLE) && win_found;
    assign last_bit = (cnt_q == CNT_W'(W - 1));
    assign id_next  = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);

    // Shared gate unit: one-hot opcode decode selects a single gate term.
    assign gate_a = a_q[cnt_q];
    assign gate_b = b_q[cnt_q];

    always_comb begin
        op_dec        = 8'b1 << op_q;
        gate_terms[0] = gate_a & gate_b;
        gate_terms[1] = gate_a | gate_b;
        gate_terms[2] = ~gate_a;
        gate_terms[3] = gate_a ^ gate_b;
        gate_terms[4] = ~(gate_a ^ gate_b);
        gate_terms[5] = ~(gate_a & gate_b);
        gate_terms[6] = ~(gate_a | gate_b);
        gate_terms[7] = 1'b0;
        gate_y        = |(op_dec & gate_terms);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept)     state_d = S_EXEC;
            S_EXEC:  if (last_bit)   state_d = S_DONE;
            S_DONE:  if (resp_ready) state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rr_d  = rr_q;
        id_d  = id_q;
        op_d  = op_q;
        a_d   = a_q;
        b_d   = b_q;
        res_d = res_q;
        cnt_d = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    id_d  = win_id;
                    op_d  = sel_op;
                    a_d   = sel_a;
                    b_d   = sel_b;
                    res_d = '0;
                    cnt_d = '0;
                end
            end
            S_EXEC: begin
                res_d[cnt_q] = gate_y;
                cnt_d        = last_bit ? '0 : cnt_q + CNT_W'(1);
            end
            S_DONE: begin
                if (resp_ready) begin
                    rr_d  = id_next;
                    id_d  = '0;
                    op_d  = '0;
                    a_d   = '0;
                    b_d   = '0;
                    res_d = '0;
                end
            end
            default: ;
        endcase
    end

    // req_ready is gated by rst_n so every output reads 0 while reset is held.
    always_comb begin
        req_ready  = '0;
        resp_valid = 1'b0;
        resp_id    = '0;
        resp_data  = '0;
        resp_err   = 1'b0;
        busy       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_found && rst_n) begin
                    req_ready[win_id] = 1'b1;
                end
            end
            S_EXEC: begin
                busy = 1'b1;
            end
            S_DONE: begin
                busy       = 1'b1;
                resp_valid = 1'b1;
                resp_id    = id_q;
                resp_data  = res_q;
                resp_err   = (op_q == OP_RSVD);
            end
            default: ;
        endcase
    end

endmodule
